// File: rtl/shift_pipe.sv
// rtl/shift_pipe.sv - multi-mode DEPTH x WIDTH shift register with tap, rotate, load, clear and fill count
module shift_pipe #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8,
    parameter int TAP_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [1:0]               mode,
    input  logic                     dir,
    input  logic [WIDTH-1:0]         in,
    input  logic [WIDTH*DEPTH-1:0]   load_data,
    input  logic [TAP_W-1:0]         tap_sel,
    output logic [WIDTH-1:0]         out,
    output logic [WIDTH-1:0]         tap,
    output logic [WIDTH*DEPTH-1:0]   data,
    output logic [CNT_W-1:0]         count,
    output logic                     full
);

    typedef enum logic [1:0] {
        MODE_SHIFT  = 2'b00,
        MODE_ROTATE = 2'b01,
        MODE_LOAD   = 2'b10,
        MODE_CLEAR  = 2'b11
    } mode_e;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [WIDTH-1:0] entry_word;
    mode_e            mode_sel;

    assign mode_sel = mode_e'(mode);

    // Rotate recirculates the exit stage of the current direction into the entry stage.
    always_comb begin
        entry_word = in;
        if (mode_sel == MODE_ROTATE) begin
            entry_word = dir ? stage_q[0] : stage_q[DEPTH-1];
        end
    end

    always_comb begin
        stage_d = stage_q;
        count_d = count_q;
        if (enable) begin
            case (mode_sel)
                MODE_SHIFT, MODE_ROTATE: begin
                    if (dir) begin
                        for (int i = 0; i < DEPTH - 1; i++) begin
                            stage_d[i] = stage_q[i+1];
                        end
                        stage_d[DEPTH-1] = entry_word;
                    end else begin
                        for (int i = 1; i < DEPTH; i++) begin
                            stage_d[i] = stage_q[i-1];
                        end
                        stage_d[0] = entry_word;
                    end
                    if (mode_sel == MODE_SHIFT && count_q != CNT_FULL) begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
                MODE_LOAD: begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_d[i] = load_data[i*WIDTH +: WIDTH];
                    end
                    count_d = CNT_FULL;
                end
                MODE_CLEAR: begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_d[i] = '0;
                    end
                    count_d = '0;
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            stage_q <= stage_d;
            count_q <= count_d;
        end
    end

    // Out-of-range tap_sel matches no stage and falls through to zero.
    always_comb begin
        tap = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tap_sel == TAP_W'(i)) begin
                tap = stage_q[i];
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_pack
            assign data[g*WIDTH +: WIDTH] = stage_q[g];
        end
    endgenerate

    assign out   = dir ? stage_q[0] : stage_q[DEPTH-1];
    assign count = count_q;
    assign full  = (count_q == CNT_FULL);

endmodule

// File: tb/tb_shift_pipe.sv
// tb/tb_shift_pipe.sv - randomized self-checking bench for shift_pipe (WIDTH=8, DEPTH=5)
module tb_shift_pipe;

    localparam int W = 8;
    localparam int D = 5;
    localparam int TW = 3;
    localparam int CW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            enable;
    logic [1:0]      mode;
    logic            dir;
    logic [W-1:0]    in_w;
    logic [W*D-1:0]  load_data;
    logic [TW-1:0]   tap_sel;
    logic [W-1:0]    out_w;
    logic [W-1:0]    tap;
    logic [W*D-1:0]  data;
    logic [CW-1:0]   count;
    logic            full;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: whole chain as one packed word, stage 0 in the low byte.
    logic [W*D-1:0]  mdata;
    int              mcnt;

    shift_pipe #(.WIDTH(W), .DEPTH(D), .TAP_W(TW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .dir(dir),
        .in(in_w), .load_data(load_data), .tap_sel(tap_sel),
        .out(out_w), .tap(tap), .data(data), .count(count), .full(full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (!enable) return;
        case (mode)
            2'b00: begin
                if (dir) mdata = (mdata >> W) | ({32'h0, in_w} << (W * (D - 1)));
                else     mdata = (mdata << W) | {32'h0, in_w};
                if (mcnt < D) mcnt++;
            end
            2'b01: begin
                if (dir) mdata = (mdata >> W) | ({32'h0, mdata[W-1:0]} << (W * (D - 1)));
                else     mdata = (mdata << W) | {32'h0, mdata[W*D-1 -: W]};
            end
            2'b10: begin
                mdata = load_data;
                mcnt  = D;
            end
            default: begin
                mdata = '0;
                mcnt  = 0;
            end
        endcase
    endtask

    task automatic check_all(input string tag);
        logic [W-1:0] exp_tap;
        logic [W-1:0] exp_out;
        exp_tap = (int'(tap_sel) < D) ? mdata[int'(tap_sel)*W +: W] : '0;
        exp_out = dir ? mdata[W-1:0] : mdata[W*D-1 -: W];
        check({tag, ".data"},  64'(data),  64'(mdata));
        check({tag, ".count"}, 64'(count), 64'(mcnt));
        check({tag, ".full"},  64'(full),  64'(mcnt == D));
        check({tag, ".out"},   64'(out_w), 64'(exp_out));
        check({tag, ".tap"},   64'(tap),   64'(exp_tap));
    endtask

    task automatic step(input logic en, input logic [1:0] md, input logic d,
                        input logic [W-1:0] din, input logic [W*D-1:0] ld,
                        input logic [TW-1:0] ts, input string tag);
        enable = en; mode = md; dir = d; in_w = din; load_data = ld; tap_sel = ts;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        mdata = '0;
        mcnt  = 0;
        check({tag, ".data"},  64'(data),  64'h0);
        check({tag, ".count"}, 64'(count), 64'h0);
        check({tag, ".full"},  64'(full),  64'h0);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; mode = 2'b00; dir = 1'b0;
        in_w = '0; load_data = '0; tap_sel = '0;
        mdata = '0; mcnt = 0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // Load then out-of-range tap selects read zero.
        step(1'b1, 2'b10, 1'b0, 8'h00, 40'h05_04_03_02_01, 3'd3, "load");
        check("load.const", 64'(data), 64'h05_04_03_02_01);
        for (int s = 5; s < 8; s++) begin
            tap_sel = TW'(s);
            #1 check_all("tap_oor");
            check("tap_oor.zero", 64'(tap), 64'h0);
        end

        // Full rotation restores contents.
        for (int k = 0; k < D; k++) step(1'b1, 2'b01, 1'b0, 8'hFF, '0, 3'd0, "rot0");
        check("rot0.restore", 64'(data), 64'h05_04_03_02_01);
        step(1'b1, 2'b01, 1'b1, 8'hFF, '0, 3'd1, "rot1");
        check("rot1.const", 64'(data), 64'h01_05_04_03_02);

        // dir re-muxes out without a clock edge.
        dir = 1'b1; #1 check("dir1.out", 64'(out_w), 64'h02);
        dir = 1'b0; #1 check("dir0.out", 64'(out_w), 64'h01);

        // Clear held off by enable, then applied.
        step(1'b0, 2'b11, 1'b0, 8'h00, '0, 3'd0, "clr_hold");
        step(1'b1, 2'b11, 1'b0, 8'h00, '0, 3'd0, "clr");

        // Reverse fill, then latency and saturation.
        step(1'b1, 2'b00, 1'b1, 8'h01, '0, 3'd4, "rev1");
        step(1'b1, 2'b00, 1'b1, 8'h02, '0, 3'd3, "rev2");
        check("rev.stage3", 64'(tap), 64'h01);
        step(1'b1, 2'b00, 1'b0, 8'hA5, '0, 3'd0, "lat0");
        for (int k = 0; k < D + 2; k++) step(1'b1, 2'b00, 1'b0, 8'h00, '0, 3'd2, "lat");
        check("sat.count", 64'(count), 64'(D));

        async_reset("arst");
        step(1'b1, 2'b00, 1'b0, 8'hAA, '0, 3'd0, "post_rst");

        // Randomized operation against the reference.
        for (int k = 0; k < 400; k++) begin
            int r;
            logic [1:0] md;
            r = $urandom_range(0, 15);
            md = (r < 9) ? 2'b00 : (r < 13) ? 2'b01 : (r < 15) ? 2'b10 : 2'b11;
            if ($urandom_range(0, 63) == 0) async_reset("rnd_rst");
            step(($urandom_range(0, 3) != 0), md, 1'($urandom),
                 W'($urandom), {8'($urandom), 32'($urandom)}, TW'($urandom), "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_pipe.md
# shift_pipe

Parametrised multi-mode shift register: a DEPTH-stage chain of WIDTH-bit stages with clock enable, selectable shift direction, rotate, parallel load, synchronous clear, a runtime-selectable tap and a fill counter. It generalises the single-bit, fixed-depth, enable-gated serial shifter. It serves as a delay line, serial/parallel converter or recirculating buffer in quiz designs and benches.

## Interface
- WIDTH, 1: bits per stage.
- DEPTH, 8: number of stages, ≥ 2.
- TAP_W, $clog2(DEPTH): width of tap_sel.
- CNT_W, $clog2(DEPTH+1): width of count.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  when 0, all state holds, whatever mode is.
- mode  in  2  00 shift, 01 rotate, 10 parallel load, 11 clear.
- dir  in  1  0: entry stage 0, exit stage DEPTH-1. 1: entry stage DEPTH-1, exit stage 0.
- in  in  WIDTH  serial input word.
- load_data  in  WIDTH*DEPTH  parallel load value; stage i = bits [i*WIDTH +: WIDTH].
- tap_sel  in  TAP_W  stage index driven onto tap.
- out  out  WIDTH  exit stage for the current dir (combinational mux of registers).
- tap  out  WIDTH  stage[tap_sel]; 0 when tap_sel ≥ DEPTH.
- data  out  WIDTH*DEPTH  all stages, same packing as load_data.
- count  out  CNT_W  number of stages holding data written since last clear/reset, 0..DEPTH.
- full  out  1  count == DEPTH.

## Operation
Reset (async, any time, including mid-operation):
- All stages clear to 0 and count clears to 0.
- As a result, out, tap and data read 0 and full reads 0 while rst is high and after it falls.

Per rising edge with enable=1:
- Shift, dir=0: stage[0]←in; stage[i]←stage[i-1]. count ← min(count+1, DEPTH).
- Shift, dir=1: stage[DEPTH-1]←in; stage[i]←stage[i+1]. count is updated the same way.
- Rotate, dir=0: stage[0]←stage[DEPTH-1], remaining stages move as in shift. in is ignored and count is unchanged.
- Rotate, dir=1: mirror image of dir=0.
- Load: stage[i]←load_data slice i; count←DEPTH.
- Clear: all stages←0; count←0.

Other rules:
- enable=0: every register holds; mode, dir and in are don't-care.
- dir may change on any cycle. The next edge uses the new dir, and out re-muxes immediately.
- count does not track direction. Reversing dir mid-fill keeps the count as is.
- There are no X sources: tap_sel out of range yields 0 and has no effect on state.

## Timing
- Latency: a word presented on in at an enabled shift edge appears on out after exactly DEPTH enabled shift edges. Edges with enable=0 add no progress.
- out, tap and full are combinational from registers plus dir/tap_sel; they carry no extra register stage.
- count saturates at DEPTH: shifting while full keeps full=1 and drops the exit word.
- Rotate with DEPTH edges returns the chain to its original contents.
- rst has priority over enable and all modes. Release takes effect on the first rising edge after rst falls.

## Test plan
- Delay line, WIDTH=1, DEPTH=8, dir=0, shift, enable=1:
  - Drive in=0 for 10 edges, then in=1.
  - out=0 through the 7th edge after the change.
  - Drop enable for 1 edge, then re-enable: out=1 after the 8th enabled edge. count=8, full=1.
- Async reset mid-fill, WIDTH=8:
  - Shift in 0x11, 0x22, 0x33.
  - Assert rst between edges: data=0, count=0 immediately, without waiting for a clock.
  - Deassert, shift 0xAA: stage[0]=0xAA, count=1.
- Load + rotate, WIDTH=4, DEPTH=4:
  - Load 0x4321: count=4.
  - Rotate dir=0 one edge: data=0x3214.
  - 3 more edges: data=0x4321.
  - Rotate dir=1 one edge: data=0x1432.
- Reverse shift and tap, WIDTH=8, DEPTH=4:
  - Clear, then shift dir=1 with 0x01, 0x02: stage[3]=0x02, stage[2]=0x01.
  - tap_sel=2 gives tap=0x01, and out=stage[0]=0x00.
  - Switch dir=0: out=stage[3]=0x02 in the same cycle.
- Saturation and clear, DEPTH=8:
  - 12 shift edges: count stays 8.
  - mode=11 with enable=0: state unchanged.
  - mode=11 with enable=1: data=0, count=0, full=0.
- Out-of-range tap, DEPTH=5 (TAP_W=3): after loading all-ones, tap_sel=5, 6 and 7 each give tap=0.
